// File: rtl/serial_mag_comparator_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    bits_used;

  modport master (
    output start, a_in, b_in,
    input  busy, done, gt, eq, lt, bits_used
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, gt, eq, lt, bits_used
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first
// differing bit. Results hold until the next accepted start.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | comparing one bit per cycle
//   DONE  | result valid, done pulses for this single cycle
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_mag_comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             gt_r;
  logic             eq_r;
  logic             lt_r;
  logic [CW-1:0]    bits_used_r;
  logic             msb_differ;
  logic             last_bit;

  assign msb_differ = a_sh[WIDTH-1] ^ b_sh[WIDTH-1];
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so a held start waits a cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (msb_differ || last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, bit counter and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      cnt         <= '0;
      gt_r        <= 1'b0;
      eq_r        <= 1'b0;
      lt_r        <= 1'b0;
      bits_used_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh        <= bus.a_in;
            b_sh        <= bus.b_in;
            cnt         <= '0;
            gt_r        <= 1'b0;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
            bits_used_r <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (msb_differ) begin
            gt_r        <= a_sh[WIDTH-1];
            lt_r        <= b_sh[WIDTH-1];
            bits_used_r <= cnt + CW'(1);
          end else if (last_bit) begin
            eq_r        <= 1'b1;
            bits_used_r <= CW'(WIDTH);
          end else begin
            a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh <= {b_sh[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == SHIFT) || (state == DONE);
  assign bus.done      = (state == DONE);
  assign bus.gt        = gt_r;
  assign bus.eq        = eq_r;
  assign bus.lt        = lt_r;
  assign bus.bits_used = bits_used_r;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and random checks for the bit-serial magnitude comparator.
module tb_serial_mag_comparator;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_mag_comparator_if #(.WIDTH(8)) bus ();

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bits examined: 8 minus index of highest differing bit, or 8 when equal.
  function automatic int ref_bits(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    for (int i = 7; i >= 0; i--)
      if (x[i]) return 8 - i;
    return 8;
  endfunction

  // Issue a start from posedge+1; returns cycle index (E0 cycle after = 1) of done.
  // Optionally scrambles the operand inputs in cycle 3 of the compare.
  task automatic do_compare(input logic [7:0] a, input logic [7:0] b,
                            input bit scramble, output int cyc, output bit seen);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc == 3) begin
        bus.a_in = ~a;
        bus.b_in = ~b;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a_in  = 8'h12;
    bus.b_in  = 8'h34;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b0) begin
        bad++;
        $display("FAIL reset_flags: busy/done/gt/eq/lt=%b required 00000",
                 {bus.busy, bus.done, bus.gt, bus.eq, bus.lt});
      end
      total++;
      if (bus.bits_used !== 4'd0) begin
        bad++;
        $display("FAIL reset_bits_used: got %0d required 0", bus.bits_used);
      end
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_start: busy=%b required 0", bus.busy);
    end
  endtask

  // Checks one directed compare against hand-computed expectations.
  task automatic test_vector(input string name, input logic [7:0] a, input logic [7:0] b,
                             input bit scramble, input logic [2:0] exp_gel,
                             input int exp_bits);
    int cyc;
    bit seen;
    do_compare(a, b, scramble, cyc, seen);
    total++;
    if (!seen || cyc != exp_bits + 1) begin
      bad++;
      $display("FAIL %s_latency: done seen=%0d at cycle %0d required cycle %0d",
               name, seen, cyc, exp_bits + 1);
    end
    total++;
    if ({bus.gt, bus.eq, bus.lt} !== exp_gel) begin
      bad++;
      $display("FAIL %s_result: gt/eq/lt=%b required %b", name,
               {bus.gt, bus.eq, bus.lt}, exp_gel);
    end
    total++;
    if (bus.bits_used !== 4'(exp_bits)) begin
      bad++;
      $display("FAIL %s_bits_used: got %0d required %0d", name, bus.bits_used, exp_bits);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL %s_after_done: busy=%b done=%b required 0 0", name, bus.busy, bus.done);
    end
  endtask

  task automatic test_msb_exit();
    test_vector("msb_exit", 8'h80, 8'h7F, 1'b0, 3'b100, 1);
  endtask

  task automatic test_equal();
    test_vector("equal_a5", 8'hA5, 8'hA5, 1'b0, 3'b010, 8);
    test_vector("equal_00", 8'h00, 8'h00, 1'b0, 3'b010, 8);
    test_vector("equal_ff", 8'hFF, 8'hFF, 1'b0, 3'b010, 8);
  endtask

  task automatic test_lsb_diff();
    test_vector("lsb_diff", 8'h3C, 8'h3D, 1'b0, 3'b001, 8);
    test_vector("lsb_diff_scramble", 8'h3C, 8'h3D, 1'b1, 3'b001, 8);
  endtask

  task automatic test_back_to_back();
    int  cyc;
    bit  seen;
    bus.start = 1'b1;
    bus.a_in  = 8'h10;
    bus.b_in  = 8'h20;
    @(posedge clk);                    // E0
    #1;
    bus.start = 1'b1;                  // cycle 1: ignored request
    bus.a_in  = 8'hFF;
    bus.b_in  = 8'h00;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy: busy=%b required 1", bus.busy);
    end
    @(posedge clk);
    #1;                                // cycle 2: start stays held
    bus.a_in = 8'h01;
    bus.b_in = 8'h00;
    @(posedge clk);
    #1;                                // cycle 3
    @(posedge clk);
    #1;                                // cycle 4: first done
    total++;
    if (bus.done !== 1'b1 || {bus.gt, bus.eq, bus.lt} !== 3'b001 || bus.bits_used !== 4'd3) begin
      bad++;
      $display("FAIL b2b_first: done=%b gt/eq/lt=%b bits=%0d required 1 001 3",
               bus.done, {bus.gt, bus.eq, bus.lt}, bus.bits_used);
    end
    @(posedge clk);
    #1;                                // cycle 5: IDLE despite held start
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lt !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b lt=%b required 0 0 1",
               bus.busy, bus.done, bus.lt);
    end
    @(posedge clk);                    // second E0
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || {bus.gt, bus.eq, bus.lt} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_second_accept: busy=%b gt/eq/lt=%b required 1 000",
               bus.busy, {bus.gt, bus.eq, bus.lt});
    end
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (!seen || cyc != 9 || {bus.gt, bus.eq, bus.lt} !== 3'b100 || bus.bits_used !== 4'd8) begin
      bad++;
      $display("FAIL b2b_second: seen=%0d cyc=%0d gt/eq/lt=%b bits=%0d required 1 9 100 8",
               seen, cyc, {bus.gt, bus.eq, bus.lt}, bus.bits_used);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit early_done;
    bus.start = 1'b1;
    bus.a_in  = 8'h55;
    bus.b_in  = 8'h55;
    @(posedge clk);                    // E0
    #1;
    bus.start  = 1'b0;
    early_done = 1'b0;
    for (int k = 1; k < 4; k++) begin  // cycles 1..3
      early_done |= bus.done;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;                        // cycle 4 of SHIFT
    @(posedge clk);
    #1;
    total++;
    if (early_done || {bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b0 ||
        bus.bits_used !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid: early_done=%0d busy/done/gt/eq/lt=%b bits=%0d required 0 00000 0",
               early_done, {bus.busy, bus.done, bus.gt, bus.eq, bus.lt}, bus.bits_used);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      early_done |= bus.done | bus.busy;
      @(posedge clk);
      #1;
    end
    total++;
    if (early_done) begin
      bad++;
      $display("FAIL reset_mid_resume: compare activity after reset, required none");
    end
    test_vector("after_reset", 8'h55, 8'h55, 1'b0, 3'b010, 8);
  endtask

  task automatic test_random();
    int         cyc;
    bit         seen;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exp_gel;
    int         exp_bits;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = (n % 4 == 0) ? a : 8'($urandom_range(0, 255));
      exp_gel  = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
      exp_bits = ref_bits(a, b);
      do_compare(a, b, 1'b0, cyc, seen);
      total++;
      if (!seen || cyc != exp_bits + 1 || {bus.gt, bus.eq, bus.lt} !== exp_gel ||
          bus.bits_used !== 4'(exp_bits)) begin
        bad++;
        $display("FAIL random a=%h b=%h: seen=%0d cyc=%0d gt/eq/lt=%b bits=%0d required cyc %0d %b %0d",
                 a, b, seen, cyc, {bus.gt, bus.eq, bus.lt}, bus.bits_used,
                 exp_bits + 1, exp_gel, exp_bits);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'h00;
    test_reset();
    test_msb_exit();
    test_equal();
    test_lsb_diff();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Bit-serial magnitude comparator built as the sequential counterpart of the team's 1-bit cascaded comparator cell. It accepts two WIDTH-bit operands on a start pulse, walks them MSB-first one bit per clock, and stops at the first differing bit. It reports a one-hot greater/equal/less result with a done pulse. It serves control paths where area matters more than latency, and it provides a self-checking companion for the 1-bit comparator benches.

## Interface
- WIDTH, 8, operand width in bits; legal range is ≥ 2
- CW, $clog2(WIDTH+1), width of the bit counter (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  reset is synchronous and active-high
- start  in  1  request a compare; sampled only in IDLE
- a_in  in  WIDTH  operand A, unsigned; captured on accepted start
- b_in  in  WIDTH  operand B, unsigned; captured on accepted start
- busy  out  1  high while in SHIFT or DONE
- done  out  1  one-cycle pulse when the result is valid
- gt  out  1  A > B
- eq  out  1  A == B
- lt  out  1  A < B
- bits_used  out  CW  number of bit positions examined for the last result (1..WIDTH)

## Operation
- FSM states:
  - IDLE: waiting for start.
  - SHIFT: comparing one bit per cycle.
  - DONE: result valid.
- IDLE → SHIFT on start=1:
  - Load a_sh←a_in and b_sh←b_in.
  - Set cnt←0.
  - Clear gt, eq and lt to 0, and clear bits_used to 0.
- SHIFT, each cycle: compare a_sh[WIDTH-1] and b_sh[WIDTH-1], then set cnt←cnt+1.
  - Bits differ: set gt←a_sh[MSB] and lt←b_sh[MSB], set bits_used←cnt+1, go to DONE. This is early termination.
  - Bits equal and cnt==WIDTH-1: set eq←1, set bits_used←WIDTH, go to DONE.
  - Bits equal otherwise: shift a_sh and b_sh left by 1 with zero fill, and stay in SHIFT.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Operands are unsigned. The shift registers are WIDTH bits, and no arithmetic is performed.
- Result hold: gt, eq, lt and bits_used hold their values from DONE onward until the next accepted start clears them.
- After a completed compare, exactly one of gt, eq and lt is 1. All three are 0 after reset and during a compare.
- start while busy is ignored. No queueing takes place.
- Operand changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, bits_used=0. The internal shift registers and cnt are also 0.
- rst has priority over every other input. Asserting rst mid-SHIFT or in DONE aborts the compare, suppresses done, and returns all outputs to their reset values at the next edge.
- Start is accepted at edge E0. busy=1 from the cycle after E0 onward.
- Latency: with n bits examined, done is high in cycle n+1 after E0. Result outputs change at the same edge that raises done.
  - Best case: MSBs differ, n=1, done appears 2 cycles after the start edge.
  - Worst case: equal operands or only the LSB differs, n=WIDTH, done appears WIDTH+1 cycles after E0.
- busy falls at the edge that leaves DONE, so busy=0 in the cycle after done.
- A start held high continuously is accepted in the first IDLE cycle after DONE. Back-to-back compares therefore occur every n+2 cycles.
- A start held high during the DONE cycle is not accepted in that cycle.

## Test plan
- Reset check: assert rst for 2 cycles with start=1 → busy, done, gt, eq, lt and bits_used are all 0, and no compare begins.
- MSB early exit: a_in=8'h80, b_in=8'h7F, start pulse → done exactly 2 cycles after the start edge, gt=1, eq=0, lt=0, bits_used=1.
- Full-length equal: a_in=b_in=8'hA5 → done 9 cycles after the start edge, eq=1, gt=0, lt=0, bits_used=8. Repeat with 8'h00 and with 8'hFF.
- LSB difference: a_in=8'h3C, b_in=8'h3D → lt=1, bits_used=8, done at cycle 9. Then change a_in and b_in mid-compare → result unaffected.
- Ignored start and back-to-back:
  - First compare: a_in=8'h10, b_in=8'h20.
  - Pulse start again in cycle 1 with a_in=8'hFF, b_in=8'h00 → the second request is ignored; the first compare gives lt=1, bits_used=3.
  - Hold start high with a_in=8'h01, b_in=8'h00 → the next accept happens in the IDLE cycle after DONE, and the result is gt=1, bits_used=8.
- Reset mid-compare: a_in=b_in=8'h55, assert rst in SHIFT cycle 4 → no done pulse, all outputs 0. A fresh compare afterwards completes normally with eq=1.
- Randomized sweep: 1000 random operand pairs checked against a reference model → exactly one of gt, eq, lt is set, and bits_used equals WIDTH minus the index of the highest differing bit, or WIDTH when the operands are equal.
